dg0040_stack_ctrl: RTL and testbench

//  Sequencer for the DG0040 5-level PC return stack (shift-register stack, MODE1/MODE0 = 10 push, 11 pop, else hold).

---
 rtl/dg0040_stack_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_dg0040_stack_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dg0040_stack_ctrl.sv
// -----------------------------------------------------------------------------
// dg0040_stack_ctrl
// Sequencer for the DG0040 5-level shift-register PC return stack.
// Turns CALL/RET requests into one-cycle MODE1/MODE0 pulses (10 push, 11 pop),
// tracks occupancy, flags overflow/underflow and captures the popped PC.
//
// Configuration macro: STK_OVF_BLOCK_EN
//   defined   : a push at FULL is refused (no MODE activity, ERR=1, OVF=1).
//   undefined : a push at FULL is performed; the oldest entry falls off the
//               bottom of the stack, DEPTH_O stays at DEPTH, OVF=1, ERR=0.
// -----------------------------------------------------------------------------
module dg0040_stack_ctrl #(
    parameter int DEPTH   = 5,
    parameter int PC_W    = 10,
    parameter int DEPTH_W = 3
) (
    input  logic               STK_CLK,
    input  logic               STK_NRST,
    input  logic               CALL_REQ,
    input  logic               RET_REQ,
    input  logic               FLUSH,
    input  logic [PC_W-1:0]    SP,
    output logic               MODE1,
    output logic               MODE0,
    output logic               ACK,
    output logic               ERR,
    output logic [PC_W-1:0]    RET_PC,
    output logic [DEPTH_W-1:0] DEPTH_O,
    output logic               FULL,
    output logic               EMPTY,
    output logic               OVF,
    output logic               UNF
);

    localparam logic [DEPTH_W-1:0] DEPTH_MAX  = DEPTH_W'(DEPTH);
    localparam logic [DEPTH_W-1:0] DEPTH_ZERO = {DEPTH_W{1'b0}};

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_PUSH = 2'b10;
    localparam logic [1:0] MODE_POP  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PUSH = 2'd1,
        ST_POP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_s;

    logic [1:0]         mode_r;
    logic [1:0]         mode_s;
    logic               ack_r;
    logic               ack_s;
    logic               err_r;
    logic               err_s;
    logic               ovf_r;
    logic               ovf_s;
    logic               unf_r;
    logic               unf_s;
    logic [PC_W-1:0]    ret_pc_r;
    logic [PC_W-1:0]    ret_pc_s;
    logic [DEPTH_W-1:0] depth_r;
    logic [DEPTH_W-1:0] depth_s;

    logic               full_s;
    logic               empty_s;

    // Occupancy after a push; the shift register cannot hold more than DEPTH.
    function automatic logic [DEPTH_W-1:0] depth_inc(input logic [DEPTH_W-1:0] d);
        logic [DEPTH_W-1:0] r;
        if (d >= DEPTH_MAX) begin
            r = DEPTH_MAX;
        end else begin
            r = d + DEPTH_W'(1);
        end
        return r;
    endfunction

    // Occupancy after a pop; never wraps below zero.
    function automatic logic [DEPTH_W-1:0] depth_dec(input logic [DEPTH_W-1:0] d);
        logic [DEPTH_W-1:0] r;
        if (d == DEPTH_ZERO) begin
            r = DEPTH_ZERO;
        end else begin
            r = d - DEPTH_W'(1);
        end
        return r;
    endfunction

    assign full_s  = (depth_r == DEPTH_MAX);
    assign empty_s = (depth_r == DEPTH_ZERO);

    // FSM state register; reset aborts any operation in flight.
    always_ff @(posedge STK_CLK or negedge STK_NRST) begin
        if (!STK_NRST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state plus next values of every registered output.
    always_comb begin
        state_s  = state_r;
        mode_s   = MODE_HOLD;
        ack_s    = 1'b0;
        err_s    = 1'b0;
        ovf_s    = 1'b0;
        unf_s    = 1'b0;
        ret_pc_s = ret_pc_r;
        depth_s  = depth_r;

        case (state_r)
            ST_IDLE: begin
                if (FLUSH) begin
                    // Clear occupancy only; stack contents are left alone.
                    depth_s = DEPTH_ZERO;
                end else if (CALL_REQ) begin
`ifdef STK_OVF_BLOCK_EN
                    if (full_s) begin
                        state_s = ST_DONE;
                        ack_s   = 1'b1;
                        err_s   = 1'b1;
                        ovf_s   = 1'b1;
                    end else begin
                        state_s = ST_PUSH;
                        mode_s  = MODE_PUSH;
                    end
`else
                    state_s = ST_PUSH;
                    mode_s  = MODE_PUSH;
`endif
                end else if (RET_REQ) begin
                    if (empty_s) begin
                        state_s = ST_DONE;
                        ack_s   = 1'b1;
                        err_s   = 1'b1;
                        unf_s   = 1'b1;
                    end else begin
                        state_s = ST_POP;
                        mode_s  = MODE_POP;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PUSH: begin
                // The stack shifts at this edge; a push at FULL loses the oldest entry.
                state_s = ST_DONE;
                ack_s   = 1'b1;
                ovf_s   = full_s;
                depth_s = depth_inc(depth_r);
            end
            ST_POP: begin
                // SP still shows the pre-shift top at this edge.
                state_s  = ST_DONE;
                ack_s    = 1'b1;
                ret_pc_s = SP;
                depth_s  = depth_dec(depth_r);
            end
            ST_DONE: begin
                // Requests seen here belong to the operation just acknowledged.
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge STK_CLK or negedge STK_NRST) begin
        if (!STK_NRST) begin
            mode_r   <= MODE_HOLD;
            ack_r    <= 1'b0;
            err_r    <= 1'b0;
            ovf_r    <= 1'b0;
            unf_r    <= 1'b0;
            ret_pc_r <= {PC_W{1'b0}};
            depth_r  <= DEPTH_ZERO;
        end else begin
            mode_r   <= mode_s;
            ack_r    <= ack_s;
            err_r    <= err_s;
            ovf_r    <= ovf_s;
            unf_r    <= unf_s;
            ret_pc_r <= ret_pc_s;
            depth_r  <= depth_s;
        end
    end

    assign MODE1   = mode_r[1];
    assign MODE0   = mode_r[0];
    assign ACK     = ack_r;
    assign ERR     = err_r;
    assign OVF     = ovf_r;
    assign UNF     = unf_r;
    assign RET_PC  = ret_pc_r;
    assign DEPTH_O = depth_r;
    assign FULL    = full_s;
    assign EMPTY   = empty_s;

endmodule

// File: tb/tb_dg0040_stack_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dg0040_stack_ctrl
// Directed bench for dg0040_stack_ctrl. A transaction-level model (a queue of
// return addresses plus per-cycle expected outputs) is compared against the
// DUT on every falling edge; literal checks pin the model at key points.
// Honours STK_OVF_BLOCK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_dg0040_stack_ctrl;

    localparam int DEPTH   = 5;
    localparam int PC_W    = 10;
    localparam int DEPTH_W = 3;

    logic               STK_CLK;
    logic               STK_NRST;
    logic               CALL_REQ;
    logic               RET_REQ;
    logic               FLUSH;
    logic [PC_W-1:0]    SP;
    logic               MODE1;
    logic               MODE0;
    logic               ACK;
    logic               ERR;
    logic [PC_W-1:0]    RET_PC;
    logic [DEPTH_W-1:0] DEPTH_O;
    logic               FULL;
    logic               EMPTY;
    logic               OVF;
    logic               UNF;

    int tests_run;
    int tests_failed;

    // Environment: the shift-register stack and the PC it pushes.
    logic [PC_W-1:0] stk [DEPTH];
    logic [PC_W-1:0] cur_pc;

    // Model: return addresses currently tracked, top at index 0.
    logic [PC_W-1:0] q [$];
    logic [1:0]      exp_mode;
    logic            exp_ack;
    logic            exp_err;
    logic            exp_ovf;
    logic            exp_unf;
    logic [PC_W-1:0] exp_ret_pc;
    bit              chk_en;
    bit              block_full;

    dg0040_stack_ctrl #(
        .DEPTH   (DEPTH),
        .PC_W    (PC_W),
        .DEPTH_W (DEPTH_W)
    ) dut (
        .STK_CLK  (STK_CLK),
        .STK_NRST (STK_NRST),
        .CALL_REQ (CALL_REQ),
        .RET_REQ  (RET_REQ),
        .FLUSH    (FLUSH),
        .SP       (SP),
        .MODE1    (MODE1),
        .MODE0    (MODE0),
        .ACK      (ACK),
        .ERR      (ERR),
        .RET_PC   (RET_PC),
        .DEPTH_O  (DEPTH_O),
        .FULL     (FULL),
        .EMPTY    (EMPTY),
        .OVF      (OVF),
        .UNF      (UNF)
    );

    initial STK_CLK = 1'b0;
    always #5 STK_CLK = ~STK_CLK;

    // Shift-register stack reacting to the MODE it sees at each edge.
    always @(posedge STK_CLK) begin
        if ({MODE1, MODE0} == 2'b10) begin
            for (int i = DEPTH - 1; i > 0; i--) stk[i] <= stk[i-1];
            stk[0] <= cur_pc;
        end else if ({MODE1, MODE0} == 2'b11) begin
            for (int i = 0; i < DEPTH - 1; i++) stk[i] <= stk[i+1];
            stk[DEPTH-1] <= '0;
        end
    end
    assign SP = stk[0];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge STK_CLK) begin
        if (chk_en) begin
            chk("mode",   32'({MODE1, MODE0}), 32'(exp_mode));
            chk("ack",    32'(ACK),     32'(exp_ack));
            chk("err",    32'(ERR),     32'(exp_err));
            chk("ovf",    32'(OVF),     32'(exp_ovf));
            chk("unf",    32'(UNF),     32'(exp_unf));
            chk("ret_pc", 32'(RET_PC),  32'(exp_ret_pc));
            chk("depth",  32'(DEPTH_O), 32'(q.size()));
            chk("full",   32'(FULL),    32'(q.size() == DEPTH));
            chk("empty",  32'(EMPTY),   32'(q.size() == 0));
        end
    end

    task automatic tick();
        @(posedge STK_CLK);
        #1;
    endtask

    task automatic clear_exp();
        exp_mode = 2'b00;
        exp_ack  = 1'b0;
        exp_err  = 1'b0;
        exp_ovf  = 1'b0;
        exp_unf  = 1'b0;
    endtask

    // One complete request/acknowledge handshake, predicted from the model.
    task automatic run_op(input bit is_call, input bit is_ret, input logic [PC_W-1:0] pc);
        bit full_b;
        bit empty_b;
        bit refused;
        full_b   = (q.size() == DEPTH);
        empty_b  = (q.size() == 0);
        refused  = is_call ? (block_full && full_b) : empty_b;
        cur_pc   = pc;
        CALL_REQ = is_call;
        RET_REQ  = is_ret;
        tick();
        if (refused) begin
            exp_ack = 1'b1;
            exp_err = 1'b1;
            exp_ovf = is_call;
            exp_unf = !is_call;
            tick();
            clear_exp();
        end else begin
            exp_mode = is_call ? 2'b10 : 2'b11;
            tick();
            exp_mode = 2'b00;
            exp_ack  = 1'b1;
            if (is_call) begin
                exp_ovf = full_b;
                if (full_b) void'(q.pop_back());
                q.push_front(pc);
            end else begin
                exp_ret_pc = q.pop_front();
            end
            tick();
            clear_exp();
        end
        CALL_REQ = 1'b0;
        RET_REQ  = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
`ifdef STK_OVF_BLOCK_EN
        block_full = 1'b1;
`else
        block_full = 1'b0;
`endif
        for (int i = 0; i < DEPTH; i++) stk[i] = '0;
        cur_pc     = '0;
        chk_en     = 1'b0;
        STK_NRST   = 1'b0;
        CALL_REQ   = 1'b0;
        RET_REQ    = 1'b0;
        FLUSH      = 1'b0;
        clear_exp();
        exp_ret_pc = '0;

        tick();
        tick();
        chk("rst_mode",  32'({MODE1, MODE0}), 32'd0);
        chk("rst_depth", 32'(DEPTH_O), 32'd0);
        chk("rst_empty", 32'(EMPTY), 32'd1);
        chk("rst_ack",   32'(ACK), 32'd0);
        STK_NRST = 1'b1;
        chk_en   = 1'b1;
        tick();

        // First push straight out of reset.
        run_op(1'b1, 1'b0, 10'h001);
        chk("lit_depth1", 32'(DEPTH_O), 32'd1);
        chk("lit_empty0", 32'(EMPTY), 32'd0);

        // Fill to FULL, then unwind in LIFO order.
        for (int i = 2; i <= DEPTH; i++) run_op(1'b1, 1'b0, PC_W'(i));
        chk("lit_full", 32'(FULL), 32'd1);
        for (int i = DEPTH; i >= 1; i--) begin
            run_op(1'b0, 1'b1, 10'h000);
            chk("lit_ret_pc", 32'(RET_PC), 32'(i));
        end
        chk("lit_empty", 32'(EMPTY), 32'd1);

        // Pop from EMPTY: refused, RET_PC keeps the last popped value.
        run_op(1'b0, 1'b1, 10'h000);
        chk("lit_unf_ret_pc", 32'(RET_PC), 32'h001);

        // Sixth push at FULL.
        for (int i = 1; i <= DEPTH; i++) run_op(1'b1, 1'b0, PC_W'(16 + i));
        run_op(1'b1, 1'b0, 10'h016);
        chk("lit_ovf_depth", 32'(DEPTH_O), 32'd5);
        run_op(1'b0, 1'b1, 10'h000);
`ifdef STK_OVF_BLOCK_EN
        chk("lit_ovf_top", 32'(RET_PC), 32'h015);
`else
        chk("lit_ovf_top", 32'(RET_PC), 32'h016);
`endif

        // FLUSH beats a simultaneous CALL: occupancy clears, no handshake.
        FLUSH    = 1'b1;
        CALL_REQ = 1'b1;
        tick();
        q.delete();
        FLUSH    = 1'b0;
        CALL_REQ = 1'b0;
        tick();
        tick();
        chk("lit_flush_depth", 32'(DEPTH_O), 32'd0);

        // CALL and RET together at depth 2: CALL wins.
        run_op(1'b1, 1'b0, 10'h021);
        run_op(1'b1, 1'b0, 10'h022);
        run_op(1'b1, 1'b1, 10'h023);
        chk("lit_both_depth", 32'(DEPTH_O), 32'd3);

        // Reset in the middle of a push at depth 3.
        cur_pc   = 10'h024;
        CALL_REQ = 1'b1;
        tick();
        exp_mode = 2'b10;
        chk("lit_push_mode", 32'({MODE1, MODE0}), 32'h2);
        #1;
        chk_en   = 1'b0;
        STK_NRST = 1'b0;
        CALL_REQ = 1'b0;
        #1;
        chk("lit_arst_mode",  32'({MODE1, MODE0}), 32'd0);
        chk("lit_arst_depth", 32'(DEPTH_O), 32'd0);
        chk("lit_arst_ack",   32'(ACK), 32'd0);
        q.delete();
        clear_exp();
        exp_ret_pc = '0;
        tick();
        tick();
        STK_NRST = 1'b1;
        chk_en   = 1'b1;
        tick();

        // Life after reset: a push/pop round trip.
        run_op(1'b1, 1'b0, 10'h031);
        run_op(1'b0, 1'b1, 10'h000);
        chk("lit_final_ret", 32'(RET_PC), 32'h031);
        tick();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
